// File: rtl/trace_ctrl_pkg.sv
// Shared types for the retire-trace capture path: FSM state encoding and the trace record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trace_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } trace_state_e;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        we;
  } trace_rec_t;

  // Retiring this encoding inside a capture window ends the window.
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

endpackage

// File: rtl/trace_ctrl_if.sv
// Retire stream from writeback plus the record stream to the trace logger.
// Latency: n/a (wires only).
// Backpressure: out_ready from the logger holds the current record on the out_* fields.
interface trace_ctrl_if;

  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic [31:0] ret_wdata;
  logic [4:0]  ret_rd;
  logic        ret_we;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_seq;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_wdata;
  logic [4:0]  out_rd;
  logic        out_we;

  // Pipeline/logger side: produces retires, consumes records.
  modport master (
    output ret_valid, ret_pc, ret_instr, ret_wdata, ret_rd, ret_we,
    output out_ready,
    input  out_valid, out_seq, out_pc, out_instr, out_wdata, out_rd, out_we
  );

  // Trace controller side.
  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_wdata, ret_rd, ret_we,
    input  out_ready,
    output out_valid, out_seq, out_pc, out_instr, out_wdata, out_rd, out_we
  );

endinterface

// File: rtl/trace_ctrl_fifo.sv
// Record FIFO, first-word-fall-through from registered storage (no write-to-read bypass).
// Latency: a written entry is visible at the head the cycle after the write.
// Backpressure: a push is taken when not full, or when a pop frees a slot in the same cycle.
module trace_fifo
  import trace_ctrl_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = trace_rec_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  rec_t          push_dat_i,
  input  logic          pop_i,
  output rec_t          pop_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  rec_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        wr_en;
  logic        rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);

  // Head is forced to zero when empty so the output fields read 0 out of reset.
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Read/write pointer update; clr_i empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/trace_ctrl.sv
// Retire-trace capture: arm/trigger/stop FSM filters retires into a record FIFO drained to the logger.
// Latency: a captured retire shows on out_valid one cycle later; FSM moves on the edge after its cause.
// Backpressure: out_ready holds the head; full FIFO drops and counts records, or, with
//   RISCVIBE_TRACE_BACKPRESSURE_EN defined, stall_req holds the pipeline at DEPTH-1 entries.
module trace_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [31:0]       trig_pc,
  input  logic              stop,
  trace_ctrl_if.slave       tif,
  output trace_state_e      state,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              stall_req
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef RISCVIBE_TRACE_BACKPRESSURE_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  trace_state_e      state_q, state_d;
  logic [31:0]       seq_q, seq_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          push, pop, drop, clr, seq_clr;
  logic          trig_hit, stop_hit;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  trace_rec_t    push_rec, head_rec;

  assign trig_hit = tif.ret_valid && (tif.ret_pc == trig_pc);
  assign stop_hit = stop || (tif.ret_valid && (tif.ret_instr == INSTR_EBREAK));

  // FSM next state plus push/clear strobes; the stopping record itself is still pushed.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    clr     = 1'b0;
    seq_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = trig_en ? ARMED : CAPTURE;
          seq_clr = 1'b1;
          clr     = (state_q == DONE);
        end
      end
      ARMED: begin
        if (trig_hit) begin
          state_d = CAPTURE;
          push    = 1'b1;
        end
      end
      CAPTURE: begin
        push = tif.ret_valid;
        if (stop_hit) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A slot freed by a same-cycle pop lets a push into a full FIFO through.
  assign pop  = !fifo_empty && tif.out_ready;
  assign drop = !BP_EN && push && fifo_full && !pop;

  // Sequence number and drop bookkeeping; seq advances even for dropped records.
  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (seq_clr)   seq_d = '0;
    else if (push) seq_d = seq_q + 32'd1;
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign push_rec = '{seq:   seq_q,
                      pc:    tif.ret_pc,
                      instr: tif.ret_instr,
                      wdata: tif.ret_wdata,
                      rd:    tif.ret_rd,
                      we:    tif.ret_we};

  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .push_i     (push),
    .push_dat_i (push_rec),
    .pop_i      (pop),
    .pop_dat_o  (head_rec),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign tif.out_valid = !fifo_empty;
  assign tif.out_seq   = head_rec.seq;
  assign tif.out_pc    = head_rec.pc;
  assign tif.out_instr = head_rec.instr;
  assign tif.out_wdata = head_rec.wdata;
  assign tif.out_rd    = head_rec.rd;
  assign tif.out_we    = head_rec.we;

  assign state     = state_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign stall_req = BP_EN && ((state_q == CAPTURE) || (state_q == ARMED))
                     && (fifo_cnt >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_trace_ctrl.sv
// Directed bench for trace_ctrl: immediate/trigger capture, EBREAK stop, overflow or stall, mid-run reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// Records the logger accepts are collected by tick() into a queue for in-order checks.
module tb_trace_ctrl;
  import trace_ctrl_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         arm;
  logic         trig_en;
  logic [31:0]  trig_pc;
  logic         stop;
  trace_state_e state;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic         stall_req;

  int checks;
  int errors;
  trace_rec_t got[$];

  trace_ctrl_if tif ();

  trace_ctrl #(
    .DEPTH  (16),
    .DROP_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .trig_en   (trig_en),
    .trig_pc   (trig_pc),
    .stop      (stop),
    .tif       (tif),
    .state     (state),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log the record the logger takes at the coming edge, then advance one cycle.
  task automatic tick();
    trace_rec_t r;
    if (tif.out_valid && tif.out_ready) begin
      r.seq = tif.out_seq; r.pc = tif.out_pc; r.instr = tif.out_instr;
      r.wdata = tif.out_wdata; r.rd = tif.out_rd; r.we = tif.out_we;
      got.push_back(r);
    end
    @(negedge clk);
  endtask

  // Retire one instruction next edge; wdata and rd are derived from pc so the bench can predict them.
  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    tif.ret_valid = 1'b1;
    tif.ret_pc    = pc;
    tif.ret_instr = instr;
    tif.ret_wdata = pc ^ 32'hA5A5_0000;
    tif.ret_rd    = pc[6:2];
    tif.ret_we    = 1'b1;
  endtask

  task automatic pulse_arm(input logic te, input logic [31:0] tpc);
    arm = 1'b1; trig_en = te; trig_pc = tpc;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
    checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", tif.out_valid); end
    checks++; if (tif.out_seq !== 32'd0) begin errors++; $display("FAIL reset_out_seq: got %h expected 0", tif.out_seq); end
    checks++; if (tif.out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", tif.out_pc); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    rst_n = 1'b1;
    tick();
    checks++; if (state !== IDLE) begin errors++; $display("FAIL post_reset_state: got %0d expected %0d", state, IDLE); end
  endtask

  task automatic test_immediate();
    logic [31:0] pc;
    tif.out_ready = 1'b1;
    pulse_arm(1'b0, 32'h0);
    checks++; if (state !== CAPTURE) begin errors++; $display("FAIL imm_arm_state: got %0d expected %0d", state, CAPTURE); end
    for (int i = 0; i < 5; i++) begin
      pc = 32'(4 * i);
      retire(pc, 32'h0000_0013);
      tick();
      checks++; if (tif.out_valid !== 1'b1) begin errors++; $display("FAIL imm_valid[%0d]: got %b expected 1", i, tif.out_valid); end
      checks++; if (tif.out_seq !== 32'(i)) begin errors++; $display("FAIL imm_seq[%0d]: got %0d expected %0d", i, tif.out_seq, i); end
      checks++; if (tif.out_pc !== pc) begin errors++; $display("FAIL imm_pc[%0d]: got %h expected %h", i, tif.out_pc, pc); end
      checks++; if (tif.out_wdata !== (pc ^ 32'hA5A5_0000)) begin errors++; $display("FAIL imm_wdata[%0d]: got %h expected %h", i, tif.out_wdata, pc ^ 32'hA5A5_0000); end
      checks++; if (tif.out_rd !== pc[6:2]) begin errors++; $display("FAIL imm_rd[%0d]: got %0d expected %0d", i, tif.out_rd, pc[6:2]); end
    end
    tif.ret_valid = 1'b0;
    // arm while capturing must be ignored
    arm = 1'b1; trig_en = 1'b1;
    tick();
    arm = 1'b0;
    checks++; if (state !== CAPTURE) begin errors++; $display("FAIL imm_arm_ignored: got %0d expected %0d", state, CAPTURE); end
    checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL imm_drained: got %b expected 0", tif.out_valid); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (state !== DRAIN) begin errors++; $display("FAIL imm_stop_state: got %0d expected %0d", state, DRAIN); end
    tick();
    checks++; if (state !== DONE) begin errors++; $display("FAIL imm_done_state: got %0d expected %0d", state, DONE); end
  endtask

  task automatic test_trigger();
    got.delete();
    tif.out_ready = 1'b1;
    pulse_arm(1'b1, 32'h20);
    checks++; if (state !== ARMED) begin errors++; $display("FAIL trig_armed: got %0d expected %0d", state, ARMED); end
    for (int i = 0; i <= 12; i++) begin
      retire(32'(4 * i), 32'h0000_0013);
      tick();
      if (i == 7) begin
        checks++; if (state !== ARMED) begin errors++; $display("FAIL trig_still_armed: got %0d expected %0d", state, ARMED); end
      end
    end
    tif.ret_valid = 1'b0;
    tick(); tick();
    checks++; if (state !== CAPTURE) begin errors++; $display("FAIL trig_capture: got %0d expected %0d", state, CAPTURE); end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL trig_count: got %0d expected 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i].pc !== 32'(32'h20 + 4 * i)) begin errors++; $display("FAIL trig_pc[%0d]: got %h expected %h", i, got[i].pc, 32'h20 + 4 * i); end
      checks++; if (got[i].seq !== 32'(i)) begin errors++; $display("FAIL trig_seq[%0d]: got %0d expected %0d", i, got[i].seq, i); end
    end
  endtask

  task automatic test_ebreak();
    got.delete();
    retire(32'h14, INSTR_EBREAK);
    tick();
    checks++; if (state !== DRAIN) begin errors++; $display("FAIL ebreak_drain: got %0d expected %0d", state, DRAIN); end
    checks++; if (tif.out_instr !== INSTR_EBREAK) begin errors++; $display("FAIL ebreak_instr: got %h expected %h", tif.out_instr, INSTR_EBREAK); end
    retire(32'h18, 32'h0000_0013);
    tick();
    retire(32'h1C, 32'h0000_0013);
    tick();
    tif.ret_valid = 1'b0;
    tick();
    checks++; if (state !== DONE) begin errors++; $display("FAIL ebreak_done: got %0d expected %0d", state, DONE); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL ebreak_count: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0].pc !== 32'h14) begin errors++; $display("FAIL ebreak_pc: got %h expected 14", got[0].pc); end
      checks++; if (got[0].seq !== 32'd5) begin errors++; $display("FAIL ebreak_seq: got %0d expected 5", got[0].seq); end
    end
  endtask

  task automatic test_overflow();
    logic exp_stall;
    int n;
    int cyc;
    got.delete();
    tif.out_ready = 1'b0;
    pulse_arm(1'b0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      retire(32'(32'h100 + 4 * i), 32'h0000_0013);
      tick();
`ifdef RISCVIBE_TRACE_BACKPRESSURE_EN
      exp_stall = (i >= 14);
`else
      exp_stall = 1'b0;
`endif
      checks++; if (stall_req !== exp_stall) begin errors++; $display("FAIL ovf_stall[%0d]: got %b expected %b", i, stall_req, exp_stall); end
    end
`ifdef RISCVIBE_TRACE_BACKPRESSURE_EN
    tif.ret_valid = 1'b0;
    tif.out_ready = 1'b1;
    n = 15;
    cyc = 0;
    while (n < 20 && cyc < 200) begin
      if (!stall_req) begin
        retire(32'(32'h100 + 4 * n), 32'h0000_0013);
        n++;
      end else begin
        tif.ret_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    tif.ret_valid = 1'b0;
    for (int k = 0; k < 24; k++) tick();
    checks++; if (got.size() != 20) begin errors++; $display("FAIL bp_count: got %0d expected 20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      checks++; if (got[i].seq !== 32'(i)) begin errors++; $display("FAIL bp_seq[%0d]: got %0d expected %0d", i, got[i].seq, i); end
    end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL bp_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b expected 0", overflow); end
`else
    n = 0;
    cyc = 0;
    for (int i = 15; i < 20; i++) begin
      retire(32'(32'h100 + 4 * i), 32'h0000_0013);
      tick();
    end
    tif.ret_valid = 1'b0;
    tick();
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 4", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_overflow: got %b expected 1", overflow); end
    checks++; if (tif.out_seq !== 32'd0) begin errors++; $display("FAIL ovf_head_held: got %0d expected 0", tif.out_seq); end
    tif.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checks++; if (got.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      checks++; if (got[i].seq !== 32'(i)) begin errors++; $display("FAIL ovf_seq[%0d]: got %0d expected %0d", i, got[i].seq, i); end
    end
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++; if (state !== DONE) begin errors++; $display("FAIL ovf_done: got %0d expected %0d (n=%0d cyc=%0d)", state, DONE, n, cyc); end
  endtask

  task automatic test_reset_mid();
    got.delete();
    tif.out_ready = 1'b0;
    pulse_arm(1'b0, 32'h0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rearm_overflow: got %b expected 0", overflow); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rearm_drop_cnt: got %0d expected 0", drop_cnt); end
    for (int i = 0; i < 6; i++) begin
      retire(32'(32'h200 + 4 * i), 32'h0000_0013);
      tick();
    end
    tif.ret_valid = 1'b0;
    checks++; if (dut.seq_q !== 32'd6) begin errors++; $display("FAIL mid_seq_before: got %0d expected 6", dut.seq_q); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", tif.out_valid); end
    checks++; if (state !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected %0d", state, IDLE); end
    checks++; if (dut.seq_q !== 32'd0) begin errors++; $display("FAIL mid_rst_seq: got %0d expected 0", dut.seq_q); end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_arm(1'b0, 32'h0);
    tif.out_ready = 1'b1;
    retire(32'h300, 32'h0000_0013);
    tick();
    tif.ret_valid = 1'b0;
    checks++; if (tif.out_seq !== 32'd0) begin errors++; $display("FAIL post_rst_seq: got %0d expected 0", tif.out_seq); end
    checks++; if (tif.out_pc !== 32'h300) begin errors++; $display("FAIL post_rst_pc: got %h expected 300", tif.out_pc); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = 32'h0; stop = 1'b0;
    tif.ret_valid = 1'b0; tif.ret_pc = 32'h0; tif.ret_instr = 32'h0;
    tif.ret_wdata = 32'h0; tif.ret_rd = 5'd0; tif.ret_we = 1'b0;
    tif.out_ready = 1'b0;
    test_reset();
    test_immediate();
    test_trigger();
    test_ebreak();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
